// File: rtl/exp_alu_arbiter.sv
// exp_alu_arbiter
//   Round-robin arbiter that shares one combinational exponent ALU between
//   N_REQ requesters. It grants at most one request per cycle, muxes the
//   winner's operands and op code onto the ALU, and captures the result
//   together with the requester index in a valid/ready output register.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b/req_op   packed per-requester operands and op codes
//   alu_a/alu_b/alu_ctrl drive the shared ALU (zeros / 2'b11 when idle)
//   alu_result           combinational result back from the ALU
//   rsp_*                registered response with backpressure
//   grant_cnt            saturating count of accepted requests
module exp_alu_arbiter #(
    parameter int N_REQ = 3,
    parameter int EW    = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*EW-1:0]   req_a,
    input  logic [N_REQ*EW-1:0]   req_b,
    input  logic [N_REQ*2-1:0]    req_op,
    output logic [EW-1:0]         alu_a,
    output logic [EW-1:0]         alu_b,
    output logic [1:0]            alu_ctrl,
    input  logic [EW-1:0]         alu_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_id,
    output logic [EW-1:0]         rsp_data,
    output logic                  rsp_err,
    output logic [15:0]           grant_cnt
);

    localparam int PW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic          gnt_found;
    logic          can_issue;
    logic          gnt_ok;

    // Output register may be reloaded when empty or being drained this cycle.
    assign can_issue = !rsp_valid || rsp_ready;

    // Round-robin search: first pass covers indices at or above ptr, the
    // second pass wraps around to the indices below it.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (i >= int'(ptr))) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!gnt_found && req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = PW'(i);
            end
        end
    end

    // rst_n gating keeps req_ready low during reset even though the
    // cleared output register would otherwise allow issue.
    assign gnt_ok = gnt_found && can_issue && rst_n;

    always_comb begin
        req_ready = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = 2'b11;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_ok && (gnt_idx == PW'(i))) begin
                req_ready[i] = 1'b1;
                alu_a        = req_a[i*EW +: EW];
                alu_b        = req_b[i*EW +: EW];
                alu_ctrl     = req_op[i*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            grant_cnt <= '0;
        end else begin
            if (gnt_ok) begin
                rsp_valid <= 1'b1;
                rsp_id    <= 3'(gnt_idx);
                rsp_data  <= alu_result;
                rsp_err   <= (alu_ctrl == 2'b11);
                if (gnt_idx == PW'(N_REQ - 1))
                    ptr <= '0;
                else
                    ptr <= gnt_idx + PW'(1);
                if (grant_cnt != 16'hFFFF)
                    grant_cnt <= grant_cnt + 16'd1;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exp_alu_arbiter.sv
module tb_exp_alu_arbiter;

    localparam int N  = 3;
    localparam int EW = 9;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*EW-1:0]   req_a;
    logic [N*EW-1:0]   req_b;
    logic [N*2-1:0]    req_op;
    logic [EW-1:0]     alu_a;
    logic [EW-1:0]     alu_b;
    logic [1:0]        alu_ctrl;
    logic [EW-1:0]     alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2:0]        rsp_id;
    logic [EW-1:0]     rsp_data;
    logic              rsp_err;
    logic [15:0]       grant_cnt;

    int total = 0;
    int bad   = 0;

    exp_alu_arbiter #(.N_REQ(N), .EW(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .grant_cnt(grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [EW-1:0] alu_fn(input logic [1:0] op,
                                             input logic [EW-1:0] a,
                                             input logic [EW-1:0] b);
        case (op)
            2'b00:   return EW'(a + b - 9'h07F);
            2'b01:   return EW'(a - b + 9'h07F);
            2'b10:   return EW'(a - b);
            default: return '0;
        endcase
    endfunction

    // Shared ALU stand-in
    always_comb alu_result = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin winner: walk indices ptr, ptr+1, ... modulo N.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // Behavioural model state
    int            m_ptr;
    bit            m_valid;
    int            m_id;
    logic [EW-1:0] m_data;
    bit            m_err;
    int            m_cnt;
    int            g_upd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_valid = 0; m_id = 0; m_data = '0; m_err = 0; m_cnt = 0;
        end else begin
            g_upd = pick(req_valid, m_ptr);
            if ((!m_valid || rsp_ready) && g_upd >= 0) begin
                m_valid = 1;
                m_id    = g_upd;
                m_data  = alu_fn(req_op[g_upd*2 +: 2], req_a[g_upd*EW +: EW], req_b[g_upd*EW +: EW]);
                m_err   = (req_op[g_upd*2 +: 2] == 2'b11);
                m_ptr   = (g_upd + 1) % N;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end else if (m_valid && rsp_ready) begin
                m_valid = 0;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        int g;
        logic [N-1:0] e_rdy;
        if (!rst_n) begin
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
            g = (!m_valid || rsp_ready) ? pick(req_valid, m_ptr) : -1;
            e_rdy = '0;
            if (g >= 0) e_rdy[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("alu_a", 32'(alu_a), (g >= 0) ? 32'(req_a[g*EW +: EW]) : 32'd0);
            chk("alu_b", 32'(alu_b), (g >= 0) ? 32'(req_b[g*EW +: EW]) : 32'd0);
            chk("alu_ctrl", 32'(alu_ctrl), (g >= 0) ? 32'(req_op[g*2 +: 2]) : 32'd3);
            chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
            chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
            if (m_valid) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_data", 32'(rsp_data), 32'(m_data));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
        end
    end

    task automatic set_req(input int i, input bit v, input logic [1:0] op,
                           input logic [EW-1:0] a, input logic [EW-1:0] b);
        req_valid[i]      = v;
        req_op[i*2 +: 2]  = op;
        req_a[i*EW +: EW] = a;
        req_b[i*EW +: EW] = b;
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_op = '0;
    endtask

    task automatic do_reset();
        @(negedge clk); #2;
        rst_n = 1'b0;
        step(2);
        @(negedge clk); #2;
        rst_n = 1'b1;
        step(1);
    endtask

    logic [EW-1:0] held;
    int            order [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        clear_reqs();
        step(3);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_grant_cnt", 32'(grant_cnt), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        step(1);

        // Idle
        #2;
        chk("idle_alu_ctrl", 32'(alu_ctrl), 32'd3);
        chk("idle_alu_a", 32'(alu_a), 32'd0);
        chk("idle_alu_b", 32'(alu_b), 32'd0);

        // Single requests
        set_req(1, 1, 2'b00, 9'h082, 9'h081);
        #1;
        chk("single1_ready", 32'(req_ready), 32'b010);
        step(1);
        clear_reqs();
        chk("single1_valid", 32'(rsp_valid), 32'd1);
        chk("single1_id", 32'(rsp_id), 32'd1);
        chk("single1_data", 32'(rsp_data), 32'h084);

        set_req(2, 1, 2'b01, 9'h082, 9'h081);
        step(1);
        clear_reqs();
        chk("single2_id", 32'(rsp_id), 32'd2);
        chk("single2_data", 32'(rsp_data), 32'h080);

        set_req(0, 1, 2'b10, 9'h005, 9'h008);
        step(1);
        clear_reqs();
        chk("single0_id", 32'(rsp_id), 32'd0);
        chk("single0_data", 32'(rsp_data), 32'h1FD);
        chk("single0_err", 32'(rsp_err), 32'd0);
        step(2);

        // Round robin with all valid from reset
        do_reset();
        set_req(0, 1, 2'b00, 9'h080, 9'h080);
        set_req(1, 1, 2'b01, 9'h090, 9'h010);
        set_req(2, 1, 2'b10, 9'h010, 9'h020);
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk("rr_valid", 32'(rsp_valid), 32'd1);
            chk("rr_order", 32'(rsp_id), 32'(order[k]));
        end
        chk("rr_cnt6", 32'(grant_cnt), 32'd6);
        req_valid = '0;
        step(1);
        chk("rr_data_last", 32'(rsp_data), 32'h1F0);

        // Backpressure
        step(1);
        rsp_ready = 1'b0;
        req_valid = 3'b111;
        step(1);
        chk("bp_one_xfer", 32'(grant_cnt), 32'd7);
        chk("bp_id", 32'(rsp_id), 32'd0);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        held = rsp_data;
        chk("bp_data0", 32'(held), 32'h081);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("bp_hold", 32'(rsp_data), 32'(held));
            chk("bp_ready_low", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b010);
        step(1);
        chk("bp_release_valid", 32'(rsp_valid), 32'd1);
        chk("bp_release_id", 32'(rsp_id), 32'd1);
        clear_reqs();
        step(2);

        // Reserved op
        set_req(0, 1, 2'b11, 9'h1FF, 9'h001);
        step(1);
        clear_reqs();
        chk("rsv_data", 32'(rsp_data), 32'd0);
        chk("rsv_err", 32'(rsp_err), 32'd1);
        chk("rsv_id", 32'(rsp_id), 32'd0);
        step(1);

        // Reset mid-operation
        rsp_ready = 1'b0;
        req_valid = 3'b111;
        step(1);
        chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_drop_valid", 32'(rsp_valid), 32'd0);
        chk("mid_ready_low", 32'(req_ready), 32'd0);
        chk("mid_cnt_clear", 32'(grant_cnt), 32'd0);
        step(1);
        req_valid = 3'b110;
        rsp_ready = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'b010);
        step(1);
        chk("post_rst_id", 32'(rsp_id), 32'd1);
        clear_reqs();
        step(1);

        // Saturation
        do_reset();
        set_req(0, 1, 2'b00, 9'h001, 9'h002);
        set_req(1, 1, 2'b01, 9'h003, 9'h004);
        set_req(2, 1, 2'b10, 9'h005, 9'h006);
        step(65540);
        chk("sat_cnt", 32'(grant_cnt), 32'h0000FFFF);
        clear_reqs();
        step(2);
        chk("sat_hold", 32'(grant_cnt), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
